// File: rtl/branch_unit_ras_pkg.sv
// Shared branch-unit types: op encoding, RAS defaults and op decode.
package cpu_br_pkg;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_BNE  = 3'd1,
    OP_BEQ  = 3'd2,
    OP_JMP  = 3'd3,
    OP_CALL = 3'd4,
    OP_RET  = 3'd5
  } br_op_t;

  localparam int DEF_RAS_DEPTH  = 8;
  localparam int RAS_PTR_W      = $clog2(DEF_RAS_DEPTH);
  localparam int DEF_INST_BYTES = 4;

  // Reserved encodings 6-7 collapse onto NONE.
  function automatic br_op_t decode_op(input logic [2:0] raw);
    br_op_t op;
    case (raw)
      3'd1, 3'd2, 3'd3, 3'd4, 3'd5: op = br_op_t'(raw);
      default:                      op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/branch_unit_ras_if.sv
// Issue-side and resolution-side signals of the branch unit.
interface branch_unit_ras_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic [2:0]      op;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs0;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] imm;
  logic            stall;
  logic            flush;
  logic            br_valid;
  logic            br_taken;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] link_addr;
  logic            ras_empty;
  logic            ras_full;
  logic            ras_ovf;

  modport master (
    output in_valid, op, pc, rs0, rs1, imm, stall, flush,
    input  br_valid, br_taken, br_target, link_addr, ras_empty, ras_full, ras_ovf
  );

  modport slave (
    input  in_valid, op, pc, rs0, rs1, imm, stall, flush,
    output br_valid, br_taken, br_target, link_addr, ras_empty, ras_full, ras_ovf
  );
endinterface

// File: rtl/branch_unit_ras_stack.sv
// Circular return-address stack. r_top indexes the newest entry; a push
// writes the slot after it, so a push on a full stack lands on the oldest.
module ras_stack
  import cpu_br_pkg::*;
#(
  parameter int DEPTH = DEF_RAS_DEPTH,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top_data,
  output logic         empty,
  output logic         full,
  output logic         ovf
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_top;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic [PTR_W-1:0] w_top_inc;
  logic [PTR_W-1:0] w_top_dec;

  assign w_top_inc = r_top + PTR_W'(1);
  assign w_top_dec = r_top - PTR_W'(1);
  assign empty     = (r_count == '0);
  assign full      = (r_count == CNT_W'(DEPTH));
  assign ovf       = r_ovf;
  assign top_data  = r_mem[r_top];

  // Entry storage: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) r_mem[w_top_inc] <= push_data;
  end

  // Pointer, occupancy and sticky overflow tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_top   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (push) begin
      r_top <= w_top_inc;
      if (full) r_ovf   <= 1'b1;
      else      r_count <= r_count + CNT_W'(1);
    end else if (pop && !empty) begin
      r_top   <= w_top_dec;
      r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/branch_unit_ras.sv
// Registered branch resolution with return-address stack; result one
// cycle after an accepted issue drives fetch redirect.
module branch_unit_ras
  import cpu_br_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int RAS_DEPTH  = DEF_RAS_DEPTH,
  parameter int INST_BYTES = DEF_INST_BYTES
) (
  input  logic              clk,
  input  logic              rst_n,
  branch_unit_ras_if.slave  bus
);
  br_op_t          w_op;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] w_link;
  logic [XLEN-1:0] w_ras_top;
  logic            w_ras_empty;
  logic            w_ras_full;
  logic            w_ras_ovf;
  logic            w_taken_p0;
  logic [XLEN-1:0] w_target_p0;

  logic            r_vld_p1;
  logic            r_taken_p1;
  logic [XLEN-1:0] r_target_p1;
  logic [XLEN-1:0] r_link_p1;

  assign w_op     = decode_op(bus.op);
  assign w_accept = bus.in_valid && !bus.stall && !bus.flush;
  assign w_push   = w_accept && (w_op == OP_CALL);
  assign w_pop    = w_accept && (w_op == OP_RET);
  assign w_sum    = bus.pc + bus.imm;
  assign w_link   = bus.pc + XLEN'(INST_BYTES);

  ras_stack #(.DEPTH(RAS_DEPTH), .W(XLEN)) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_link),
    .top_data  (w_ras_top),
    .empty     (w_ras_empty),
    .full      (w_ras_full),
    .ovf       (w_ras_ovf)
  );

  // Stage p0: compare and target select from the issuing operands.
  always_comb begin
    w_taken_p0  = 1'b0;
    w_target_p0 = '0;
    case (w_op)
      OP_BNE:  begin w_taken_p0 = (bus.rs0 != bus.rs1); w_target_p0 = w_sum; end
      OP_BEQ:  begin w_taken_p0 = (bus.rs0 == bus.rs1); w_target_p0 = w_sum; end
      OP_JMP,
      OP_CALL: begin w_taken_p0 = 1'b1;                 w_target_p0 = w_sum; end
      OP_RET:  begin
        w_taken_p0  = 1'b1;
        w_target_p0 = w_ras_empty ? bus.rs0 : w_ras_top;
      end
      default: begin w_taken_p0 = 1'b0;                 w_target_p0 = '0;    end
    endcase
  end

  // Stage p1: result registers; flush beats stall, idle cycles keep data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1    <= 1'b0;
      r_taken_p1  <= 1'b0;
      r_target_p1 <= '0;
      r_link_p1   <= '0;
    end else if (bus.flush) begin
      r_vld_p1   <= 1'b0;
      r_taken_p1 <= 1'b0;
    end else if (!bus.stall) begin
      r_vld_p1 <= bus.in_valid;
      if (bus.in_valid) begin
        r_taken_p1  <= w_taken_p0;
        r_target_p1 <= w_target_p0;
        r_link_p1   <= w_link;
      end
    end
  end

  assign bus.br_valid  = r_vld_p1;
  assign bus.br_taken  = r_taken_p1;
  assign bus.br_target = r_target_p1;
  assign bus.link_addr = r_link_p1;
  assign bus.ras_empty = w_ras_empty;
  assign bus.ras_full  = w_ras_full;
  assign bus.ras_ovf   = w_ras_ovf;

endmodule

// File: tb/tb_branch_unit_ras.sv
// Directed bench for branch_unit_ras with a 4-entry RAS.
module tb_branch_unit_ras;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  branch_unit_ras_if #(.XLEN(32)) bus ();

  branch_unit_ras #(.XLEN(32), .RAS_DEPTH(4), .INST_BYTES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] pc,
                       input logic [31:0] rs0, input logic [31:0] rs1, input logic [31:0] imm,
                       input logic st, input logic fl);
    bus.in_valid = v;   bus.op  = op;  bus.pc  = pc;
    bus.rs0      = rs0; bus.rs1 = rs1; bus.imm = imm;
    bus.stall    = st;  bus.flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, $urandom, 1'b0, 1'b0);
      tick();
    end
    vectors++; if (bus.br_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got=%0h exp=0", bus.br_valid); end
    vectors++; if (bus.br_taken !== 1'b0) begin miscompares++; $display("FAIL rst_taken got=%0h exp=0", bus.br_taken); end
    vectors++; if (bus.br_target !== 32'h0) begin miscompares++; $display("FAIL rst_target got=%h exp=0", bus.br_target); end
    vectors++; if (bus.link_addr !== 32'h0) begin miscompares++; $display("FAIL rst_link got=%h exp=0", bus.link_addr); end
    vectors++; if (bus.ras_empty !== 1'b1 || bus.ras_full !== 1'b0 || bus.ras_ovf !== 1'b0) begin
      miscompares++; $display("FAIL rst_ras got=e%0h f%0h o%0h exp=e1 f0 o0", bus.ras_empty, bus.ras_full, bus.ras_ovf); end
    drive(1'b0, 3'd0, 0, 0, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    vectors++; if (bus.br_valid !== 1'b0) begin miscompares++; $display("FAIL rst_idle_valid got=%0h exp=0", bus.br_valid); end
  endtask

  task automatic test_bne_beq();
    drive(1'b1, 3'd1, 32'h100, 32'hF, 32'hF0, 32'hF000, 1'b0, 1'b0);
    tick();
    vectors++; if (bus.br_valid !== 1'b1) begin miscompares++; $display("FAIL bne_valid got=%0h exp=1", bus.br_valid); end
    vectors++; if (bus.br_taken !== 1'b1) begin miscompares++; $display("FAIL bne_taken got=%0h exp=1", bus.br_taken); end
    vectors++; if (bus.br_target !== 32'hF100) begin miscompares++; $display("FAIL bne_target got=%h exp=0000f100", bus.br_target); end
    drive(1'b1, 3'd2, 32'h100, 32'hF, 32'hF0, 32'hF000, 1'b0, 1'b0);
    tick();
    vectors++; if (bus.br_taken !== 1'b0) begin miscompares++; $display("FAIL beq_nt_taken got=%0h exp=0", bus.br_taken); end
    vectors++; if (bus.br_target !== 32'hF100) begin miscompares++; $display("FAIL beq_nt_target got=%h exp=0000f100", bus.br_target); end
    drive(1'b1, 3'd2, 32'h100, 32'hF0, 32'hF0, 32'hF000, 1'b0, 1'b0);
    tick();
    vectors++; if (bus.br_taken !== 1'b1) begin miscompares++; $display("FAIL beq_t_taken got=%0h exp=1", bus.br_taken); end
    drive(1'b1, 3'd1, 32'h100, 32'hF0, 32'hF0, 32'hF000, 1'b0, 1'b0);
    tick();
    vectors++; if (bus.br_taken !== 1'b0) begin miscompares++; $display("FAIL bne_nt_taken got=%0h exp=0", bus.br_taken); end
  endtask

  task automatic test_call_ret();
    drive(1'b1, 3'd4, 32'h100, 32'h0, 32'h0, 32'hF000, 1'b0, 1'b0);
    tick();
    vectors++; if (bus.br_taken !== 1'b1 || bus.br_target !== 32'hF100) begin
      miscompares++; $display("FAIL call_target got=t%0h %h exp=t1 0000f100", bus.br_taken, bus.br_target); end
    vectors++; if (bus.link_addr !== 32'h104) begin miscompares++; $display("FAIL call_link got=%h exp=00000104", bus.link_addr); end
    vectors++; if (bus.ras_empty !== 1'b0) begin miscompares++; $display("FAIL call_empty got=%0h exp=0", bus.ras_empty); end
    drive(1'b1, 3'd5, 32'h0, 32'hF0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    vectors++; if (bus.br_taken !== 1'b1 || bus.br_target !== 32'h104) begin
      miscompares++; $display("FAIL ret_target got=t%0h %h exp=t1 00000104", bus.br_taken, bus.br_target); end
    vectors++; if (bus.ras_empty !== 1'b1) begin miscompares++; $display("FAIL ret_empty got=%0h exp=1", bus.ras_empty); end
  endtask

  task automatic test_ret_empty();
    drive(1'b1, 3'd5, 32'h0, 32'hF0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    vectors++; if (bus.br_taken !== 1'b1 || bus.br_target !== 32'hF0) begin
      miscompares++; $display("FAIL ret_empty_target got=t%0h %h exp=t1 000000f0", bus.br_taken, bus.br_target); end
    vectors++; if (bus.ras_empty !== 1'b1 || bus.ras_full !== 1'b0) begin
      miscompares++; $display("FAIL ret_empty_ptr got=e%0h f%0h exp=e1 f0", bus.ras_empty, bus.ras_full); end
    drive(1'b0, 3'd3, 32'h500, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    vectors++; if (bus.br_valid !== 1'b0) begin miscompares++; $display("FAIL idle_valid got=%0h exp=0", bus.br_valid); end
    vectors++; if (bus.br_taken !== 1'b1 || bus.br_target !== 32'hF0) begin
      miscompares++; $display("FAIL idle_hold got=t%0h %h exp=t1 000000f0", bus.br_taken, bus.br_target); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_t [5];
    exp_t = '{32'h54, 32'h44, 32'h34, 32'h24, 32'hAA};
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 3'd4, 32'(i * 16), 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      tick();
      vectors++; if (bus.ras_full !== (i >= 4)) begin
        miscompares++; $display("FAIL ovf_full_%0d got=%0h exp=%0h", i, bus.ras_full, (i >= 4)); end
      vectors++; if (bus.ras_ovf !== (i == 5)) begin
        miscompares++; $display("FAIL ovf_flag_%0d got=%0h exp=%0h", i, bus.ras_ovf, (i == 5)); end
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'd5, 32'h0, 32'hAA, 32'h0, 32'h0, 1'b0, 1'b0);
      tick();
      vectors++; if (bus.br_target !== exp_t[i]) begin
        miscompares++; $display("FAIL ovf_ret_%0d got=%h exp=%h", i, bus.br_target, exp_t[i]); end
    end
    vectors++; if (bus.ras_empty !== 1'b1 || bus.ras_ovf !== 1'b1) begin
      miscompares++; $display("FAIL ovf_end got=e%0h o%0h exp=e1 o1", bus.ras_empty, bus.ras_ovf); end
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 3'd2, 32'h200, 32'h5, 32'h5, 32'h8, 1'b0, 1'b0);
    tick();
    vectors++; if (bus.br_valid !== 1'b1 || bus.br_taken !== 1'b1 || bus.br_target !== 32'h208) begin
      miscompares++; $display("FAIL sf_beq got=v%0h t%0h %h exp=v1 t1 00000208", bus.br_valid, bus.br_taken, bus.br_target); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd4, 32'h0, 32'h1, 32'h2, 32'h0, 1'b1, 1'b0);
      tick();
      vectors++; if (bus.br_valid !== 1'b1 || bus.br_taken !== 1'b1 || bus.br_target !== 32'h208 || bus.ras_empty !== 1'b1) begin
        miscompares++; $display("FAIL sf_stall_%0d got=v%0h t%0h %h e%0h exp=v1 t1 00000208 e1", i, bus.br_valid, bus.br_taken, bus.br_target, bus.ras_empty); end
    end
    drive(1'b1, 3'd4, 32'h300, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    tick();
    vectors++; if (bus.br_valid !== 1'b0 || bus.br_taken !== 1'b0) begin
      miscompares++; $display("FAIL sf_flush got=v%0h t%0h exp=v0 t0", bus.br_valid, bus.br_taken); end
    vectors++; if (bus.ras_empty !== 1'b1) begin miscompares++; $display("FAIL sf_flush_ras got=%0h exp=1", bus.ras_empty); end
    drive(1'b1, 3'd5, 32'h0, 32'hBB, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    vectors++; if (bus.br_target !== 32'hBB) begin miscompares++; $display("FAIL sf_ret_after_flush got=%h exp=000000bb", bus.br_target); end
    drive(1'b1, 3'd3, 32'hFFFF_FFF0, 32'h0, 32'h0, 32'h20, 1'b0, 1'b0);
    tick();
    vectors++; if (bus.br_taken !== 1'b1 || bus.br_target !== 32'h10) begin
      miscompares++; $display("FAIL jmp_wrap got=t%0h %h exp=t1 00000010", bus.br_taken, bus.br_target); end
  endtask

  task automatic test_reserved();
    drive(1'b1, 3'd6, 32'h100, 32'h1, 32'h1, 32'h40, 1'b0, 1'b0);
    tick();
    vectors++; if (bus.br_valid !== 1'b1 || bus.br_taken !== 1'b0 || bus.br_target !== 32'h0) begin
      miscompares++; $display("FAIL rsvd got=v%0h t%0h %h exp=v1 t0 0", bus.br_valid, bus.br_taken, bus.br_target); end
    drive(1'b1, 3'd0, 32'h100, 32'h1, 32'h1, 32'h40, 1'b0, 1'b0);
    tick();
    vectors++; if (bus.br_valid !== 1'b1 || bus.br_taken !== 1'b0 || bus.br_target !== 32'h0) begin
      miscompares++; $display("FAIL none got=v%0h t%0h %h exp=v1 t0 0", bus.br_valid, bus.br_taken, bus.br_target); end
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 3'd4, 32'h700, 32'h0, 32'h0, 32'h10, 1'b0, 1'b0);
    tick();
    vectors++; if (bus.br_target !== 32'h710 || bus.link_addr !== 32'h704) begin
      miscompares++; $display("FAIL mr_call got=%h %h exp=00000710 00000704", bus.br_target, bus.link_addr); end
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.br_valid !== 1'b0 || bus.br_taken !== 1'b0 || bus.br_target !== 32'h0 || bus.link_addr !== 32'h0) begin
      miscompares++; $display("FAIL mr_out got=v%0h t%0h %h %h exp=all 0", bus.br_valid, bus.br_taken, bus.br_target, bus.link_addr); end
    vectors++; if (bus.ras_empty !== 1'b1 || bus.ras_ovf !== 1'b0) begin
      miscompares++; $display("FAIL mr_ras got=e%0h o%0h exp=e1 o0", bus.ras_empty, bus.ras_ovf); end
    drive(1'b0, 3'd0, 0, 0, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    drive(1'b0, 3'd0, 0, 0, 0, 0, 1'b0, 1'b0);
    test_reset();
    test_bne_beq();
    test_call_ret();
    test_ret_empty();
    test_overflow();
    test_stall_flush();
    test_reserved();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_unit_ras.md
Name: branch_unit_ras

Overview:
- Registered branch-resolution stage for the pipelined CPU; successor to the combinational branch calculator.
- Resolves BNE, BEQ, JMP, CALL and RET. Computes the taken flag and target one cycle after issue.
- Adds a parametrised circular return-address stack (RAS) so CALL/RET pairs resolve without a register read.
- Sits between decode/register-read and fetch. Its outputs drive the fetch redirect and the front-end flush.

Parameters:
- XLEN, 32, datapath width of PC, operands, immediate and target.
- RAS_DEPTH, 8, number of RAS entries; power of two, minimum 2.
- INST_BYTES, 4, link increment (return address = pc + INST_BYTES).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  branch-class instruction present this cycle.
- op  in  3  br_op_t: NONE=0, BNE=1, BEQ=2, JMP=3, CALL=4, RET=5; 6-7 reserved, treated as NONE.
- pc  in  XLEN  PC of the issuing instruction.
- rs0  in  XLEN  register operand 0; also the fallback RET target.
- rs1  in  XLEN  register operand 1.
- imm  in  XLEN  sign-extended offset.
- stall  in  1  pipeline hold.
- flush  in  1  squash from a later stage.
- br_valid  out  1  registered result valid.
- br_taken  out  1  redirect fetch.
- br_target  out  XLEN  redirect address.
- link_addr  out  XLEN  pc + INST_BYTES, meaningful when the resolved op is CALL.
- ras_empty  out  1  RAS count == 0.
- ras_full  out  1  RAS count == RAS_DEPTH.
- ras_ovf  out  1  sticky: a CALL overwrote a live entry.

Behaviour:
- Reset (async, rst_n low): all outputs 0, RAS top pointer 0, count 0, ras_ovf 0. RAS entry contents are don't-care.
- Accept rule: an input is accepted on a rising edge when in_valid && !stall && !flush. Results register on that edge (latency 1).
- Taken rules:
  - BNE: taken iff rs0 != rs1.
  - BEQ: taken iff rs0 == rs1.
  - JMP, CALL: always taken.
  - RET: always taken.
  - NONE/reserved: br_valid=1, br_taken=0, br_target=0.
- Target rules:
  - BNE, BEQ, JMP, CALL: pc + imm, modulo 2^XLEN; carry discarded.
  - RET with a non-empty RAS: top entry.
  - RET with an empty RAS: rs0.
  - Not-taken BNE/BEQ: br_target still reports pc + imm.
- RAS push: an accepted CALL pushes pc + INST_BYTES.
  - top = (top+1) mod RAS_DEPTH.
  - count saturates at RAS_DEPTH.
  - If count was already RAS_DEPTH, the oldest entry is overwritten and ras_ovf sets.
- RAS pop: an accepted RET with count>0 decrements count and moves top back by one (mod RAS_DEPTH). RET on an empty RAS leaves the pointers unchanged.
- RAS update timing: pushes and pops occur on the same edge the result registers. Back-to-back CALL then RET therefore returns the just-pushed address.
- Cycles with no accept: br_valid=0 on the next edge. br_taken, br_target and link_addr hold their previous values.
- stall=1: all registers and the RAS hold; br_valid holds.
- flush=1: overrides stall.
  - Next edge: br_valid=0 and br_taken=0.
  - The input is discarded; RAS unchanged.
- Reset mid-operation: immediate return to reset state; any in-flight result is lost.
- ras_ovf clears only on reset.
- ras_empty and ras_full are combinational from count.

Decomposition:
- Shared package cpu_br_pkg holds:
  - br_op_t enum;
  - localparam RAS_PTR_W = $clog2(RAS_DEPTH);
  - default INST_BYTES.
- Sub-module ras_stack(clk, rst_n, push, pop, push_data, top_data, empty, full, ovf): circular-buffer return-address stack instantiated once.
- The top level holds the compare, adder and output registers.

Test Plan:
- Reset: hold rst_n=0 with random inputs → all outputs 0, ras_empty=1. Deassert with in_valid=0 → br_valid stays 0.
- BNE/BEQ: pc=0x100, imm=0xF000, rs0=0xF, rs1=0xF0, op=BNE → next cycle br_taken=1, br_target=0xF100. Repeat with op=BEQ → br_taken=0. With rs0=rs1=0xF0 and op=BEQ → br_taken=1.
- CALL then RET:
  - CALL at pc=0x100, imm=0xF000 → target 0xF100, link_addr=0x104, count 1.
  - Following RET with rs0=0xF0 → target 0x104, ras_empty=1.
- RET on empty RAS with rs0=0xF0 → br_taken=1, br_target=0xF0, pointers unchanged.
- Overflow with RAS_DEPTH=4:
  - CALLs at pc=0x10,0x20,0x30,0x40,0x50 → ras_full after the 4th CALL, ras_ovf=1 after the 5th.
  - Five RETs (rs0=0xAA) → targets 0x54, 0x44, 0x34, 0x24, then 0xAA (empty fallback).
- Stall/flush:
  - BEQ taken is accepted; next cycle stall=1 for 3 cycles → outputs frozen.
  - CALL presented with stall=1, flush=1 → br_valid=0, RAS count unchanged.
  - pc=0xFFFFFFF0, imm=0x20, JMP → br_target=0x10 (wrap).
